// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It holds the fetch PC and issues one word fetch at a
// time to a variable-latency instruction memory over a req/ack handshake. Fetched
// words go into a small FIFO, and the FIFO head is presented to decode as
// {inst, pc, pc+4} with a valid/ready handshake. Execute can redirect fetch
// (taken branch/jal/jalr). A redirect flushes the FIFO and, if a memory request
// is still in flight, discards its data. A level-sensitive halt (ebreak) stops
// new fetches but lets the in-flight fetch and the FIFO contents drain.
//
// Parameters
//   RESET_PC  first PC fetched after reset
//   QDEPTH    fetch FIFO depth; power of two, >= 2
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous, active-high reset
//   imem_req     fetch request, held until imem_ack
//   imem_addr    word address of the request (bits[1:0] always 0)
//   imem_ack     response valid this cycle (only meaningful while imem_req=1)
//   imem_rdata   instruction word, valid with imem_ack
//   redirect     flush and refetch from redirect_pc
//   redirect_pc  new fetch target; bits[1:0] ignored
//   halt         while high, no new fetches are issued
//   id_valid     id_* carry a valid instruction
//   id_ready     decode accepts the head entry this cycle
//   id_inst      instruction (NOP 32'h0000_0013 when id_valid=0)
//   id_pc        PC of id_inst (0 when id_valid=0)
//   id_pc4       id_pc + 4 modulo 2^32 (0 when id_valid=0)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // control from execute
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  // decode interface
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  localparam int unsigned     PTR_W      = $clog2(QDEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(QDEPTH);
  localparam logic [PTR_W:0]  CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [31:0]     NOP_INST   = 32'h0000_0013;

  // Fetch control states:
  //   RUN   - no request in flight; decides whether to issue the next one
  //   WAIT  - request in flight; its data is pushed into the FIFO on ack
  //   DRAIN - request in flight but made stale by a redirect; data is dropped
  //   HALT  - halted, nothing in flight
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]  state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  // Address of the in-flight request. It is kept apart from fetch_pc because a
  // redirect during DRAIN moves fetch_pc, but the memory must still see the
  // old address until it acks.
  logic [31:0] req_addr, req_addr_next;

  // FIFO storage and bookkeeping
  logic [31:0]      inst_q [QDEPTH];
  logic [31:0]      pc_q   [QDEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  logic        push, pop;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsbs;

  // Redirect targets are always word aligned. The low bits of redirect_pc
  // are dropped on purpose.
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The request is a pure state decode. It is high for exactly the cycles in
  // which a fetch is in flight, so the address cannot move while it is high.
  assign imem_req  = (state == ST_WAIT) || (state == ST_DRAIN);
  assign imem_addr = req_addr;

  // Only a live (WAIT) response is kept. A redirect in the same cycle makes it
  // stale. A push can never hit a full FIFO, because RUN issues only when a
  // slot is free and nothing else fills the FIFO.
  assign push = (state == ST_WAIT) && imem_ack && !redirect;

  // A redirect flushes the FIFO, so a simultaneous pop has no effect.
  assign pop  = id_valid && id_ready && !redirect;

  // ---------------------------------------------------------------------------
  // Next-state logic for the fetch controller
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a default at the top of the block, so no path
  // through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;

    if (redirect) begin
      // A redirect overrides push, pop and halt. A fetch still in flight
      // without an ack must be drained. An ack in this same cycle completes
      // that fetch, and its data is dropped here.
      fetch_pc_next = redirect_target;
      if ((state == ST_WAIT) || (state == ST_DRAIN)) begin
        state_next = imem_ack ? ST_RUN : ST_DRAIN;
      end else begin
        state_next = ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (halt) begin
            state_next = ST_HALT;
          end else if (count < FULL_COUNT) begin
            // Nothing is in flight in RUN, so the free-slot test only needs
            // to look at the FIFO occupancy.
            state_next    = ST_WAIT;
            req_addr_next = fetch_pc;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            state_next    = ST_RUN;
            fetch_pc_next = fetch_pc + 32'd4;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            state_next = ST_RUN;
          end
        end
        ST_HALT: begin
          if (!halt) begin
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Controller and FIFO bookkeeping registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, whatever order the
  // assignments are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Slots are read only when count says
  // they were written, so clearing count and the pointers is enough. This
  // keeps the array a plain memory.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]   <= req_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-facing outputs
  // ---------------------------------------------------------------------------
  // With no valid entry, decode sees a NOP at PC 0. Stale FIFO contents never
  // appear on the bus.
  assign id_valid = (count != '0);
  assign id_inst  = id_valid ? inst_q[rd_ptr]          : NOP_INST;
  assign id_pc    = id_valid ? pc_q[rd_ptr]            : 32'd0;
  assign id_pc4   = id_valid ? pc_q[rd_ptr] + 32'd4    : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Testbench for fetch_unit. A behavioural instruction memory with configurable
// latency sits on the imem port (latency 0 = ack in the same cycle as req).
// Each scenario queues the {pc, inst} words that decode should receive, in
// order. A negedge monitor pops and compares an entry on every accepted
// handshake. Inputs are driven 1 time unit after the rising edge, and outputs
// are sampled either at the falling edge or 1 unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int unsigned QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4)
  );

  // ---------------------------------------------------------------------------
  // Instruction memory model: content is a fixed function of the address
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr ^ 32'hA5A5_5A5A) + 32'h0000_0013;
  endfunction

  int mem_lat  = 0;
  int wait_cnt = 0;

  assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int ack_cnt  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: pc, inst: mem_word(pc)});
      pc = pc + 32'd4;
    end
  endtask

  // Decode-side monitor. A redirect in the same cycle cancels the pop.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && imem_req && imem_ack) ack_cnt++;
    if (!rst && id_valid && id_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("deliv_unexpected", {31'd0, id_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("deliv_pc",   id_pc,   e.pc);
        check("deliv_inst", id_inst, e.inst);
        check("deliv_pc4",  id_pc4,  e.pc + 32'd4);
      end
      n_deliv++;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two cycles, checks the reset-state outputs and clears the
  // scoreboard. The caller releases rst.
  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    halt     = 1'b0;
    step();
    step();
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_inst",  id_inst, NOP_INST);
    check("rst_id_pc",    id_pc,   32'd0);
    check("rst_id_pc4",   id_pc4,  32'd0);
    exp_q.delete();
    n_deliv = 0;
    ack_cnt = 0;
  endtask

  task automatic wait_req_addr(input string tag, input logic [31:0] addr, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (imem_req && imem_addr == addr) break;
      step();
    end
    check(tag, {31'd0, imem_req && imem_addr == addr}, 32'd1);
  endtask

  task automatic wait_deliv(input string tag, input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (n_deliv >= n) break;
      step();
    end
    check(tag, n_deliv, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int  cyc;
    logic saw;

    // 1) Zero-wait memory, decode always ready: one fetch per two cycles.
    mem_lat  = 0;
    id_ready = 1'b1;
    do_reset();
    expect_seq(RESET_PC, 8);
    rst = 1'b0;
    step();
    check("t1_first_req",   {31'd0, imem_req}, 32'd1);
    check("t1_first_addr",  imem_addr, RESET_PC);
    check("t1_no_valid_c1", {31'd0, id_valid}, 32'd0);
    step();
    check("t1_valid_c2",    {31'd0, id_valid}, 32'd1);
    cyc = 2;
    while (n_deliv < 8 && cyc < 100) begin
      step();
      cyc++;
    end
    id_ready = 1'b0;
    check("t1_cycles_for_8", cyc, 17);
    check("t1_q_empty", exp_q.size(), 0);

    // 2) Three-cycle latency, decode stalled: FIFO fills, then fetch stops.
    mem_lat  = 3;
    id_ready = 1'b0;
    do_reset();
    expect_seq(RESET_PC, 6);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check("t2_acks",      ack_cnt, QDEPTH);
    check("t2_req_low",   {31'd0, imem_req}, 32'd0);
    check("t2_head_valid", {31'd0, id_valid}, 32'd1);
    check("t2_head_pc",   id_pc, RESET_PC);
    id_ready = 1'b1;
    wait_deliv("t2_resume_deliv", 6, 200);
    id_ready = 1'b0;
    check("t2_q_empty", exp_q.size(), 0);

    // 3) Redirect while the fetch of 0x10 is pending: 0x10 is discarded.
    mem_lat  = 3;
    id_ready = 1'b1;
    do_reset();
    expect_seq(RESET_PC, 4);
    rst = 1'b0;
    wait_req_addr("t3_pending_0x10", 32'h0000_0010, 100);
    check("t3_deliv_before", n_deliv, 4);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    exp_q.delete();
    expect_seq(32'h0000_0100, 3);
    step();
    redirect = 1'b0;
    check("t3_drain_req",  {31'd0, imem_req}, 32'd1);
    check("t3_drain_addr", imem_addr, 32'h0000_0010);
    saw = 1'b0;
    for (int c = 0; c < 50; c++) begin
      saw = saw | id_valid;
      if (imem_req && imem_addr == 32'h0000_0100) break;
      step();
    end
    check("t3_next_addr",     imem_addr, 32'h0000_0100);
    check("t3_valid_in_gap",  {31'd0, saw}, 32'd0);
    wait_deliv("t3_target_deliv", 7, 100);
    id_ready = 1'b0;
    check("t3_q_empty", exp_q.size(), 0);

    // 4) Redirect in the same cycle as an ack and a pop.
    mem_lat  = 0;
    id_ready = 1'b0;
    do_reset();
    expect_seq(RESET_PC, 1);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (imem_req && imem_ack && id_valid) break;
      step();
    end
    check("t4_setup", {31'd0, imem_req && imem_ack && id_valid}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    id_ready    = 1'b1;
    exp_q.delete();
    expect_seq(32'h0000_0200, 2);
    step();
    redirect = 1'b0;
    check("t4_flushed_valid", {31'd0, id_valid}, 32'd0);
    check("t4_flushed_inst",  id_inst, NOP_INST);
    check("t4_flushed_pc",    id_pc,   32'd0);
    check("t4_flushed_pc4",   id_pc4,  32'd0);
    step();
    check("t4_req",  {31'd0, imem_req}, 32'd1);
    check("t4_addr", imem_addr, 32'h0000_0200);
    wait_deliv("t4_target_deliv", 2, 50);
    id_ready = 1'b0;
    check("t4_q_empty", exp_q.size(), 0);

    // 5) Halt with a request pending: that word completes, then fetch stops.
    mem_lat  = 3;
    id_ready = 1'b1;
    do_reset();
    expect_seq(RESET_PC, 2);
    rst = 1'b0;
    wait_req_addr("t5_pending_0x4", 32'h0000_0004, 100);
    halt    = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) step();
    check("t5_halt_acks",  ack_cnt, 1);
    check("t5_halt_deliv", n_deliv, 2);
    check("t5_halt_req",   {31'd0, imem_req}, 32'd0);
    check("t5_halt_q",     exp_q.size(), 0);
    expect_seq(32'h0000_0008, 2);
    halt = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (imem_req) break;
      step();
    end
    check("t5_resume_req",  {31'd0, imem_req}, 32'd1);
    check("t5_resume_addr", imem_addr, 32'h0000_0008);
    wait_deliv("t5_resume_deliv", 4, 100);
    id_ready = 1'b0;
    check("t5_q_empty", exp_q.size(), 0);

    // 6) Wrap at the top of the address space, then reset mid-request.
    mem_lat  = 0;
    id_ready = 1'b1;
    do_reset();
    expect_seq(32'hFFFF_FFFC, 3);
    rst         = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (id_valid && id_pc == 32'hFFFF_FFFC) break;
      step();
    end
    check("t6_top_pc",  id_pc,  32'hFFFF_FFFC);
    check("t6_top_pc4", id_pc4, 32'd0);
    for (int c = 0; c < 20; c++) begin
      if (imem_req && imem_addr != 32'hFFFF_FFFC) break;
      step();
    end
    check("t6_wrap_addr", imem_addr, 32'd0);
    wait_deliv("t6_wrap_deliv", 3, 50);
    id_ready = 1'b0;
    mem_lat  = 20;
    check("t6_q_empty", exp_q.size(), 0);
    for (int c = 0; c < 20; c++) begin
      if (imem_req) break;
      step();
    end
    step();
    step();
    check("t6_pending_before_rst", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    step();
    check("t6_rst_req_low", {31'd0, imem_req}, 32'd0);
    do_reset();
    mem_lat  = 0;
    id_ready = 1'b1;
    expect_seq(RESET_PC, 2);
    rst = 1'b0;
    step();
    check("t6_restart_req",  {31'd0, imem_req}, 32'd1);
    check("t6_restart_addr", imem_addr, RESET_PC);
    wait_deliv("t6_restart_deliv", 2, 50);
    id_ready = 1'b0;
    check("t6_restart_q_empty", exp_q.size(), 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
